gate_vector_checker: RTL



---
 rtl/gate_vector_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - sweeps a 2-input gate through all input vectors and checks it against TRUTH
// Optional build macro: STOP_ON_FAIL_EN ends the run on the first mismatching vector.
module gate_vector_checker #(
  parameter logic [3:0] TRUTH  = 4'b1110,
  parameter int         SETTLE = 2,
  parameter int         PASSES = 1
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       start,
  input  logic       gate_out,
  output logic       in_a,
  output logic       in_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] fail_idx,
  output logic [1:0] vec_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // settle counter counts down to zero, so it is loaded with SETTLE-1
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

`ifdef STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  logic [2:0] state;
  logic [3:0] settle_cnt;
  logic [3:0] pass_cnt;
  logic       first_fail;

  logic       mismatch;
  logic [7:0] err_next;
  logic       run_end;
  logic [1:0] vec_next;

  // busy is decoded straight from state so an async reset clears it at once
  assign busy = (state != S_IDLE);

  // compare result for the current vector and the updated (saturating) error count
  always_comb begin
    mismatch = (gate_out != TRUTH[vec_idx]);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end
    vec_next = vec_idx + 2'd1;
    run_end  = ((vec_idx == 2'd3) && (pass_cnt == PASS_LAST)) || (STOP_ON_FAIL && mismatch);
  end

  // main sequencer: drive vector, wait settle, sample and score, advance
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= S_IDLE;
      in_a       <= 1'b0;
      in_b       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      fail_idx   <= 2'd0;
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      pass_cnt   <= 4'd0;
      first_fail <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count  <= 8'd0;
            pass       <= 1'b0;
            fail_idx   <= 2'd0;
            first_fail <= 1'b0;
            pass_cnt   <= 4'd0;
            vec_idx    <= 2'd0;
            in_a       <= 1'b0;
            in_b       <= 1'b0;
            state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail) begin
            fail_idx   <= vec_idx;
            first_fail <= 1'b1;
          end
          if (run_end) begin
            // pass is published together with done, from the post-compare count
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
            state <= S_DONE;
          end else begin
            vec_idx <= vec_next;
            in_a    <= vec_next[1];
            in_b    <= vec_next[0];
            if (vec_idx == 2'd3) begin
              pass_cnt <= pass_cnt + 4'd1;
            end
            state <= S_DRIVE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
